// File: rtl/arf_pkg.sv
// ARF result checker: shared constants, enums and the node schedule ROM.
// Optional build macro ARF_CHK_STICKY_EN adds a HALT state to the FSM.
package arf_pkg;

   localparam int W_DEF = 16;
   localparam int NODES = 28;

   // Operator constants; truncate to the datapath width at the use site.
   localparam int C3  = 3;
   localparam int CN3 = -3;

   typedef enum logic {
      OP_MUL,
      OP_ADD
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EVAL,
      ST_WAIT,
      ST_CMP
`ifdef ARF_CHK_STICKY_EN
      ,
      ST_HALT
`endif
   } state_e;

   // Operand source codes: 0..27 node n(k), 32..39 sample x(k), 48/49 consts.
   localparam logic [5:0] SRC_C3  = 6'd48;
   localparam logic [5:0] SRC_CN3 = 6'd49;

   function automatic logic [5:0] nd(input int k);
      return 6'(k - 1);
   endfunction

   function automatic logic [5:0] xs(input int k);
      return 6'(31 + k);
   endfunction

   typedef struct packed {
      op_e        op;
      logic [5:0] a;
      logic [5:0] b;
   } sched_t;

   localparam sched_t SCHED [NODES] = '{
      '{OP_MUL, xs(1), SRC_C3},
      '{OP_MUL, xs(2), SRC_C3},
      '{OP_MUL, xs(3), SRC_C3},
      '{OP_MUL, xs(4), SRC_C3},
      '{OP_MUL, xs(5), SRC_C3},
      '{OP_MUL, xs(6), SRC_C3},
      '{OP_MUL, xs(7), SRC_C3},
      '{OP_MUL, xs(8), SRC_C3},
      '{OP_ADD, nd(1), nd(2)},
      '{OP_ADD, nd(3), nd(4)},
      '{OP_ADD, nd(5), nd(6)},
      '{OP_ADD, nd(7), nd(8)},
      '{OP_ADD, nd(10), nd(11)},
      '{OP_ADD, nd(11), nd(12)},
      '{OP_MUL, nd(13), SRC_C3},
      '{OP_MUL, nd(14), SRC_C3},
      '{OP_MUL, nd(13), SRC_C3},
      '{OP_MUL, nd(14), SRC_C3},
      '{OP_ADD, nd(15), nd(16)},
      '{OP_ADD, nd(17), nd(18)},
      '{OP_MUL, nd(19), SRC_CN3},
      '{OP_MUL, nd(20), SRC_CN3},
      '{OP_MUL, nd(19), SRC_CN3},
      '{OP_MUL, nd(20), SRC_C3},
      '{OP_ADD, nd(21), nd(22)},
      '{OP_ADD, nd(23), nd(24)},
      '{OP_ADD, nd(9), nd(25)},
      '{OP_ADD, nd(12), nd(26)}
   };

endpackage

// File: rtl/arf_result_checker_if.sv
// ARF result checker: sample and result beat handshake bundle.
// master = stimulus/DUT side, slave = checker side.
interface arf_result_checker_if
   import arf_pkg::*;
#(
   parameter int W = W_DEF
) ();

   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data;
   logic         r_valid;
   logic         r_ready;
   logic [W-1:0] r_out27;
   logic [W-1:0] r_out28;

   modport master (
      output s_valid, s_data, r_valid, r_out27, r_out28,
      input  s_ready, r_ready
   );

   modport slave (
      input  s_valid, s_data, r_valid, r_out27, r_out28,
      output s_ready, r_ready
   );

endinterface

// File: rtl/arf_op_unit.sv
// ARF result checker: shared W-bit operator, multiply or add.
// Products keep the low W bits; sums wrap.
module arf_op_unit
   import arf_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // Select the operation for the current schedule step.
   always_comb begin
      y = '0;
      unique case (op)
         OP_MUL: y = a * b;
         OP_ADD: y = a + b;
      endcase
   end

endmodule

// File: rtl/arf_result_checker.sv
// ARF result checker: loads 8 samples, evaluates the golden graph serially,
// compares the DUT result beat. Optional macro: ARF_CHK_STICKY_EN (HALT).
module arf_result_checker
   import arf_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   arf_result_checker_if.slave bus,
   input  logic                clr,
   output logic                done,
   output logic                pass,
   output logic [CNT_W-1:0]    eval_cnt,
   output logic [CNT_W-1:0]    mism_cnt
);

   localparam logic [W-1:0] K3  = W'(C3);
   localparam logic [W-1:0] KN3 = W'(CN3);

   state_e       state;
   logic [2:0]   beat;
   logic [4:0]   step;
   logic [W-1:0] x    [8];
   logic [W-1:0] node [NODES];
   sched_t       cur;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] op_y;
   logic         match;

   function automatic logic [W-1:0] src(input logic [5:0] s);
      logic [W-1:0] r;
      r = '0;
      unique case (1'b1)
         s == SRC_CN3:      r = KN3;
         s == SRC_C3:       r = K3;
         s[5:3] == 3'b100:  r = x[s[2:0]];
         default:           r = node[s[4:0]];
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign cur   = SCHED[step];
   assign match = (bus.r_out27 == node[26]) && (bus.r_out28 == node[27]);

   // Fetch both operands of the current schedule step.
   always_comb begin
      op_a = src(cur.a);
      op_b = src(cur.b);
   end

   arf_op_unit #(.W(W)) u_op (
      .op (cur.op),
      .a  (op_a),
      .b  (op_b),
      .y  (op_y)
   );

   // Checker FSM: load, serial evaluate, wait for result, compare, count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         bus.s_ready <= 1'b0;
         bus.r_ready <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         eval_cnt    <= '0;
         mism_cnt    <= '0;
         beat        <= '0;
         step        <= '0;
         for (int i = 0; i < 8; i++) x[i] <= '0;
         for (int i = 0; i < NODES; i++) node[i] <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               state       <= ST_LOAD;
               bus.s_ready <= 1'b1;
               beat        <= '0;
            end
            ST_LOAD: begin
               if (bus.s_valid && bus.s_ready) begin
                  x[beat] <= bus.s_data;
                  beat    <= beat + 1'b1;
                  if (beat == 3'd7) begin
                     state       <= ST_EVAL;
                     bus.s_ready <= 1'b0;
                     step        <= '0;
                  end
               end
            end
            ST_EVAL: begin
               node[step] <= op_y;
               step       <= step + 1'b1;
               if (step == 5'(NODES - 1)) begin
                  state       <= ST_WAIT;
                  bus.r_ready <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (bus.r_valid && bus.r_ready) begin
                  bus.r_ready <= 1'b0;
                  pass        <= match;
                  done        <= 1'b1;
                  eval_cnt    <= sat_inc(eval_cnt);
                  if (!match) mism_cnt <= sat_inc(mism_cnt);
                  state       <= ST_CMP;
               end
            end
            ST_CMP: begin
`ifdef ARF_CHK_STICKY_EN
               if (!pass) begin
                  state <= ST_HALT;
               end else begin
                  state       <= ST_LOAD;
                  bus.s_ready <= 1'b1;
                  beat        <= '0;
               end
`else
               state       <= ST_LOAD;
               bus.s_ready <= 1'b1;
               beat        <= '0;
`endif
            end
`ifdef ARF_CHK_STICKY_EN
            ST_HALT: begin
               if (clr) state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
         // Clear dominates any increment on the same edge.
         if (clr) begin
            eval_cnt <= '0;
            mism_cnt <= '0;
         end
      end
   end

endmodule
